// File: rtl/tmds_channel_decoder.sv
// TMDS receive-side channel decoder: word alignment via bitslip, control-token and 8b data decode.
// Optional statistics outputs (bitslip and unlock counters) are enabled with `define TMDS_DEC_STATS_EN.
module tmds_channel_decoder #(
    parameter int CTRL_RUN_MIN   = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_SETTLE    = 16,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_data,
    output logic [7:0] o_data,
    output logic       o_de,
    output logic       o_c0,
    output logic       o_c1,
    output logic       o_ctrl,
    output logic       o_aligned,
`ifdef TMDS_DEC_STATS_EN
    output logic [15:0] o_slip_cnt,
    output logic [15:0] o_unlock_cnt,
`endif
    output logic       o_bitslip
);

    localparam int SYM_MAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
    localparam int SYM_W   = $clog2(SYM_MAX) + 1;
    localparam int RUN_W   = $clog2(CTRL_RUN_MIN) + 1;
    localparam int SET_W   = $clog2(SLIP_SETTLE) + 1;

    localparam logic [SYM_W-1:0] SEARCH_LAST = SYM_W'(SEARCH_TIMEOUT - 1);
    localparam logic [SYM_W-1:0] LOCK_LAST   = SYM_W'(LOCK_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(CTRL_RUN_MIN - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SLIP_SETTLE - 1);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [SYM_W-1:0] sym_cnt, sym_next;
    logic [RUN_W-1:0] run_cnt, run_next;
    logic [SET_W-1:0] settle_cnt, settle_next;

    logic       is_ctrl;
    logic [1:0] ctrl_bits;
    logic [7:0] q;
    logic [7:0] dec;
    logic       lock_hit;
    logic       unlock_hit;

    always_comb begin
        is_ctrl   = 1'b1;
        ctrl_bits = 2'b00;
        case (i_data)
            10'h354: ctrl_bits = 2'b00;
            10'h0AB: ctrl_bits = 2'b01;
            10'h154: ctrl_bits = 2'b10;
            10'h2AB: ctrl_bits = 2'b11;
            default: is_ctrl   = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q      = i_data[9] ? ~i_data[7:0] : i_data[7:0];
        dec    = 8'h00;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = i_data[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    assign lock_hit   = (state == SEARCH) && is_ctrl && (run_cnt == RUN_LAST);
    assign unlock_hit = (state == LOCKED) && !is_ctrl && (sym_cnt == LOCK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            sym_cnt    <= '0;
            run_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            sym_cnt    <= sym_next;
            run_cnt    <= run_next;
            settle_cnt <= settle_next;
        end
    end

    always_comb begin
        state_next  = state;
        sym_next    = sym_cnt;
        run_next    = run_cnt;
        settle_next = settle_cnt;
        case (state)
            SEARCH: begin
                sym_next = sym_cnt + 1'b1;
                run_next = is_ctrl ? run_cnt + 1'b1 : '0;
                // A completed control run takes priority over the search timeout.
                if (lock_hit) begin
                    state_next = LOCKED;
                    sym_next   = '0;
                    run_next   = '0;
                end else if (sym_cnt == SEARCH_LAST) begin
                    state_next  = SLIP_WAIT;
                    sym_next    = '0;
                    run_next    = '0;
                    settle_next = '0;
                end
            end
            SLIP_WAIT: begin
                settle_next = settle_cnt + 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_next  = SEARCH;
                    sym_next    = '0;
                    run_next    = '0;
                    settle_next = '0;
                end
            end
            LOCKED: begin
                run_next = '0;
                if (is_ctrl) begin
                    sym_next = '0;
                end else if (unlock_hit) begin
                    state_next = SEARCH;
                    sym_next   = '0;
                end else begin
                    sym_next = sym_cnt + 1'b1;
                end
            end
            default: begin
                state_next  = SEARCH;
                sym_next    = '0;
                run_next    = '0;
                settle_next = '0;
            end
        endcase
    end

    always_comb begin
        o_aligned = (state == LOCKED);
        o_bitslip = (state == SEARCH) && !lock_hit && (sym_cnt == SEARCH_LAST);
    end

    // o_de follows the alignment state that will be visible alongside this output.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data <= 8'h00;
            o_de   <= 1'b0;
            o_c0   <= 1'b0;
            o_c1   <= 1'b0;
            o_ctrl <= 1'b0;
        end else if (is_ctrl) begin
            o_ctrl <= 1'b1;
            o_de   <= 1'b0;
            o_c1   <= ctrl_bits[1];
            o_c0   <= ctrl_bits[0];
        end else begin
            o_ctrl <= 1'b0;
            o_data <= dec;
            o_de   <= (state_next == LOCKED);
        end
    end

`ifdef TMDS_DEC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_slip_cnt   <= 16'h0000;
            o_unlock_cnt <= 16'h0000;
        end else begin
            if (o_bitslip && (o_slip_cnt != 16'hFFFF)) begin
                o_slip_cnt <= o_slip_cnt + 16'h0001;
            end
            if (unlock_hit && (o_unlock_cnt != 16'hFFFF)) begin
                o_unlock_cnt <= o_unlock_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: decode table, lock/slip/unlock timing, resets.
module tb_tmds_channel_decoder;

    logic       clk;
    logic       rst;
    logic [9:0] i_data;
    logic [7:0] o_data;
    logic       o_de, o_c0, o_c1, o_ctrl, o_aligned, o_bitslip;
`ifdef TMDS_DEC_STATS_EN
    logic [15:0] o_slip_cnt, o_unlock_cnt;
`endif

    tmds_channel_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .o_data    (o_data),
        .o_de      (o_de),
        .o_c0      (o_c0),
        .o_c1      (o_c1),
        .o_ctrl    (o_ctrl),
        .o_aligned (o_aligned),
`ifdef TMDS_DEC_STATS_EN
        .o_slip_cnt   (o_slip_cnt),
        .o_unlock_cnt (o_unlock_cnt),
`endif
        .o_bitslip (o_bitslip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] din;
        logic [7:0] data;
        logic       de;
        logic       ctrl;
        logic       c1;
        logic       c0;
    } vec_t;

    vec_t vecs[13];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic slip_now;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock: present din, capture the combinational bitslip, advance past the edge.
    task automatic step(input logic [9:0] din);
        i_data = din;
        #1;
        slip_now = o_bitslip;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(10'h100);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, int'(o_data), 0);
        check({tag, "_flags"}, int'({o_de, o_c0, o_c1, o_ctrl, o_aligned, o_bitslip}), 0);
    endtask

    initial begin
        int p0, p1, p2, pcnt, de_seen, al_seen, slip_seen, first;

        vecs[0]  = '{10'h100, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{10'h200, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{10'h0AB, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{10'h1FF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{10'h055, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{10'h154, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{10'h155, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{10'h10F, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{10'h00F, 8'hEF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{10'h2AB, 8'hEF, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{10'h3F0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{10'h2AA, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{10'h354, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};

        rst    = 1'b1;
        i_data = 10'h100;
        @(posedge clk);
        #1;
        do_reset();
        check_all_zero("reset");

        // Unaligned stream: pulses at cycles 2047, 4111, 6175.
        p0 = -1; p1 = -1; p2 = -1; pcnt = 0; de_seen = 0; al_seen = 0;
        for (int k = 0; k < 6180; k++) begin
            step((k % 2) ? 10'h200 : 10'h100);
            if (slip_now) begin
                if (pcnt == 0) p0 = k;
                if (pcnt == 1) p1 = k;
                if (pcnt == 2) p2 = k;
                pcnt++;
            end
            if (o_de) de_seen++;
            if (o_aligned) al_seen++;
        end
        check("slip_pulse_count", pcnt, 3);
        check("slip_first_cycle", p0, 2047);
        check("slip_second_cycle", p1, 4111);
        check("slip_third_cycle", p2, 6175);
        check("unaligned_de_seen", de_seen, 0);
        check("unaligned_aligned_seen", al_seen, 0);
`ifdef TMDS_DEC_STATS_EN
        check("stats_slip_cnt", int'(o_slip_cnt), 3);
`endif

        // Reset while in SLIP_WAIT: counters restart, next pulse 2047 cycles later.
        do_reset();
        check_all_zero("rst_slipwait");
`ifdef TMDS_DEC_STATS_EN
        check("stats_slip_cnt_rst", int'(o_slip_cnt), 0);
`endif
        first = -1;
        for (int k = 0; k < 2048; k++) begin
            step(10'h100);
            if (slip_now && first < 0) first = k;
        end
        check("slip_after_reset_cycle", first, 2047);

        // Lock completing on the timeout cycle must win over the bitslip.
        do_reset();
        slip_seen = 0;
        for (int k = 0; k < 2040; k++) step(10'h100);
        for (int k = 2040; k < 2048; k++) begin
            step(10'h354);
            if (slip_now) slip_seen++;
        end
        check("lock_vs_timeout_slip", slip_seen, 0);
        check("lock_vs_timeout_aligned", int'(o_aligned), 1);

        // Plain lock on 20 tokens of 0x354.
        do_reset();
        slip_seen = 0;
        for (int j = 1; j <= 20; j++) begin
            step(10'h354);
            if (slip_now) slip_seen++;
            check($sformatf("lock_aligned_%0d", j), int'(o_aligned), (j >= 8) ? 1 : 0);
        end
        check("lock_ctrl_flags", int'({o_ctrl, o_de, o_c1, o_c0}), 4'b1000);
        check("lock_no_slip", slip_seen, 0);

        for (int v = 0; v < 13; v++) begin
            step(vecs[v].din);
            check($sformatf("vec%0d_data", v), int'(o_data), int'(vecs[v].data));
            check($sformatf("vec%0d_flags", v), int'({o_de, o_ctrl, o_c1, o_c0}),
                  int'({vecs[v].de, vecs[v].ctrl, vecs[v].c1, vecs[v].c0}));
            check($sformatf("vec%0d_aligned", v), int'(o_aligned), 1);
        end

        // 4096 data tokens while locked: lock drops after the last, with no bitslip.
        slip_seen = 0;
        for (int n = 1; n <= 4096; n++) begin
            step(10'h100);
            if (slip_now) slip_seen++;
            if (n == 4095) begin
                check("unlock_4095_aligned", int'(o_aligned), 1);
                check("unlock_4095_de", int'(o_de), 1);
            end
        end
        check("unlock_4096_aligned", int'(o_aligned), 0);
        check("unlock_4096_de", int'(o_de), 0);
        check("unlock_no_slip", slip_seen, 0);
`ifdef TMDS_DEC_STATS_EN
        check("stats_unlock_cnt", int'(o_unlock_cnt), 1);
`endif

        for (int j = 1; j <= 8; j++) begin
            step(10'h2AB);
            if (j == 7) check("relock_7_aligned", int'(o_aligned), 0);
        end
        check("relock_8_aligned", int'(o_aligned), 1);
        check("relock_ctrl_flags", int'({o_ctrl, o_de, o_c1, o_c0}), 4'b1011);

        // Reset while LOCKED.
        step(10'h200);
        do_reset();
        check_all_zero("rst_locked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the DVI TX TMDS encoder, one instance per TMDS channel.
- Takes parallel 10-bit symbols from a 1:10 deserializer on the pixel clock. Recovers word alignment by issuing bitslip requests, then decodes control tokens (C1/C0, i.e. HS/VS on channel 0) and 8-bit pixel data with DE.
- Feeds a future DVI RX top that rebuilds {B,G,R}, hs, vs and de for the snake display pipeline.

Parameters:
- CTRL_RUN_MIN, 8: consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 2048: symbols in SEARCH without lock before a bitslip is issued; must exceed one 720p line (1650).
- SLIP_SETTLE, 16: cycles waited after a bitslip before searching again.
- LOCK_TIMEOUT, 4096: symbols in LOCKED with no control token before lock is dropped.

Ports:
- clk, input, 1: pixel clock (pxl_clk domain).
- rst, input, 1: synchronous reset, active-high.
- i_data, input, 10: deserialized symbol; bit0 is first on the wire.
- o_data, output, 8: decoded pixel byte.
- o_de, output, 1: data token decoded and channel aligned.
- o_c0, output, 1: control bit C0 (HS on channel 0).
- o_c1, output, 1: control bit C1 (VS on channel 0).
- o_ctrl, output, 1: current symbol is a control token.
- o_aligned, output, 1: alignment FSM in LOCKED.
- o_bitslip, output, 1: one-cycle pulse to the deserializer to rotate the word by one bit.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0, FSM = SEARCH, all counters 0. A reset mid-slip or mid-lock abandons state immediately.
- Latency: i_data sampled at edge N drives o_data/o_de/o_c*/o_ctrl from edge N+1 (one register stage). No stalls; one symbol per clk.
- Control token table, {C1,C0}: 0x354→00, 0x0AB→01, 0x154→10, 0x2AB→11.
- On a control token:
  - o_ctrl=1, o_de=0, o_c1/o_c0 from the table.
  - o_data holds its previous value.
- On any other 10-bit code (data token):
  - q = i_data[9] ? ~i_data[7:0] : i_data[7:0].
  - o_data[0] = q[0].
  - For i=1..7: o_data[i] = i_data[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
  - o_ctrl=0; o_c1/o_c0 hold.
  - o_de=1 only when o_aligned=1 in that same output cycle; otherwise o_de=0 and o_data is still decoded.
- TERC4/guard-band codes are not recognised; they decode as data.
- FSM SEARCH:
  - sym_cnt increments every cycle.
  - run_cnt increments on a control token and clears on a data token.
  - run_cnt reaching CTRL_RUN_MIN → LOCKED; o_aligned=1 from the next cycle, sym_cnt cleared.
  - Else sym_cnt == SEARCH_TIMEOUT-1 → o_bitslip=1 for exactly one cycle, → SLIP_WAIT.
- FSM SLIP_WAIT:
  - Counts SLIP_SETTLE cycles; tokens are ignored for alignment, o_aligned=0.
  - At the end → SEARCH with sym_cnt=run_cnt=0.
- FSM LOCKED:
  - sym_cnt clears on any control token.
  - sym_cnt reaching LOCK_TIMEOUT-1 → SEARCH; o_aligned drops next cycle; counters cleared; no bitslip is issued on this transition.
- Boundary cases:
  - Lock completion and timeout in the same SEARCH cycle: lock wins.
  - o_bitslip never asserts outside the SEARCH→SLIP_WAIT transition.
  - All counters saturate-free. Widths are sized to hold their parameter, i.e. clog2(param)+1 bits, with compare-equal terminal counts.

Optional Feature:
- TMDS_DEC_STATS_EN.
- Defined:
  - Adds output o_slip_cnt[15:0]: bitslips issued since reset, saturating at 0xFFFF.
  - Adds output o_unlock_cnt[15:0]: LOCKED→SEARCH transitions, saturating.
  - Both counters are reset to 0 by rst.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then 20 cycles of 0x354 → o_c1=0, o_c0=0, o_ctrl=1, o_de=0. o_aligned rises on the cycle after the 8th token. o_bitslip stays 0.
- Locked channel fed 0x100, 0x200, 0x0AB → o_data=0x00 with o_de=1, then 0xFF with o_de=1, then o_ctrl=1 with o_c0=1, o_c1=0. Each response appears one cycle after the input.
- Alternating 0x100/0x200 from reset (no control tokens) → o_bitslip pulses at cycle 2047. Further pulses follow every 2048+16 cycles; o_aligned stays 0 and o_de stays 0.
- Lock, then 4096 consecutive data tokens → o_aligned falls after the 4096th and o_bitslip is not pulsed. Then 8 tokens of 0x2AB → relock, with o_c1=o_c0=1.
- Assert rst for one cycle during SLIP_WAIT and during LOCKED → all outputs 0 on the next cycle, FSM in SEARCH. With TMDS_DEC_STATS_EN: three forced timeouts → o_slip_cnt=3, then rst → 0.
